countdown_timer: RTL

Loadable down-counter with terminal-count pulse. It is the decrementing counterpart of the team's up-counter primitive and shares its parameter set. A start value is written through a valid/ready load port. The block counts toward zero on enabled cycles, then pulses tc and either stops (one-shot) or reloads (auto-reload). It is used for interval timers, frame/packet length countdown and timeout generation.

---
 rtl/countdown_timer.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/countdown_timer.sv
// countdown_timer: loadable down-counter with a one-cycle terminal-count pulse.
// A start value is loaded through a valid/ready port. The counter decrements by
// STEP on enabled cycles, then pulses tc and either stops (one-shot) or reloads
// (auto-reload). The last step clamps to zero, so the counter never wraps.
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous active-low reset
//   en          count enable
//   abort       synchronous stop; overrides count, terminal and load
//   load_valid  load request
//   load_ready  load accepted this cycle if load_valid (combinational)
//   load_value  start / reload value
//   auto_reload mode select, sampled only on a load accepted in IDLE
//   out         current count (registered)
//   busy        high while running (registered)
//   tc          terminal-count pulse (registered)
module countdown_timer #(
  parameter string       ARCHITECTURE = "BEHAVIORAL",
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned STEP         = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  abort,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [DATA_WIDTH-1:0] load_value,
  input  logic                  auto_reload,
  output logic [DATA_WIDTH-1:0] out,
  output logic                  busy,
  output logic                  tc
);

  localparam logic [DATA_WIDTH-1:0] STEP_W = DATA_WIDTH'(STEP);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Vendor-specific implementations are reserved names only; all variants
  // fall back to the behavioral datapath below.
  if (ARCHITECTURE != "BEHAVIORAL") begin : g_arch_placeholder
  end

  state_t                state;
  state_t                state_d;
  logic [DATA_WIDTH-1:0] out_d;
  logic                  busy_d;
  logic                  tc_d;
  logic [DATA_WIDTH-1:0] reload_reg;
  logic [DATA_WIDTH-1:0] reload_d;
  logic                  mode_reg;
  logic                  mode_d;
  logic                  accept;

  // Loads are taken in IDLE, or in RUN only to retarget an auto-reload period.
  assign load_ready = !abort && ((state == IDLE) || ((state == RUN) && mode_reg));
  assign accept     = load_valid && load_ready;

  // State register and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      out        <= '0;
      busy       <= 1'b0;
      tc         <= 1'b0;
      reload_reg <= '0;
      mode_reg   <= 1'b0;
    end else begin
      state      <= state_d;
      out        <= out_d;
      busy       <= busy_d;
      tc         <= tc_d;
      reload_reg <= reload_d;
      mode_reg   <= mode_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d  = state;
    out_d    = out;
    busy_d   = busy;
    tc_d     = 1'b0;
    reload_d = reload_reg;
    mode_d   = mode_reg;

    if (abort) begin
      state_d = IDLE;
      out_d   = '0;
      busy_d  = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            if (load_value != '0) begin
              out_d    = load_value;
              reload_d = load_value;
              mode_d   = auto_reload;
              busy_d   = 1'b1;
              state_d  = RUN;
            end else begin
              // Zero load terminates immediately without entering RUN.
              out_d = '0;
              tc_d  = 1'b1;
            end
          end
        end

        RUN: begin
          // Mid-run load only retargets the next period; a zero value
          // converts the run to one-shot at its next terminal.
          if (accept) begin
            reload_d = load_value;
            if (load_value == '0) begin
              mode_d = 1'b0;
            end
          end

          if (en) begin
            if (out > STEP_W) begin
              out_d = out - STEP_W;
            end else begin
              tc_d = 1'b1;
              if (mode_reg) begin
                // Reload uses the register value from before any same-edge load.
                out_d = reload_reg;
              end else begin
                out_d   = '0;
                busy_d  = 1'b0;
                state_d = IDLE;
              end
            end
          end
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

endmodule
